// File: rtl/jace_video_pkg.sv
// jace_video_pkg: shared timing constants, counter widths and fetch phases for the Jupiter Ace video generator.
// Contents: DEF_* default PAL timing, HC_W/VC_W counter widths, PH_* character-cell fetch phases,
//           hc_t/vc_t counter types, in_range() window helper.
package jace_video_pkg;
   localparam int DEF_H_TOTAL  = 416;
   localparam int DEF_V_TOTAL  = 312;
   localparam int DEF_H_ACTIVE = 256;
   localparam int DEF_V_ACTIVE = 192;
   localparam int DEF_HS_START = 320;
   localparam int DEF_HS_LEN   = 32;
   localparam int DEF_VS_START = 248;
   localparam int DEF_VS_LEN   = 8;
   localparam int DEF_INT_LEN  = 64;

   localparam int HC_W = 9;
   localparam int VC_W = 9;

   localparam logic [2:0] PH_SADDR = 3'd0;
   localparam logic [2:0] PH_SCODE = 3'd2;
   localparam logic [2:0] PH_CADDR = 3'd3;
   localparam logic [2:0] PH_PAT   = 3'd5;
   localparam logic [2:0] PH_LOAD  = 3'd7;

   typedef logic [HC_W-1:0] hc_t;
   typedef logic [VC_W-1:0] vc_t;

   function automatic logic in_range(input int v, input int lo, input int len);
      return v >= lo && v < lo + len;
   endfunction
endpackage

// File: rtl/jace_char_shifter.sv
// jace_char_shifter: 8-bit pixel shifter with inverse-on-load and a registered blanking gate.
// Ports: clk, rst_n (sync, active low), load (take new pattern), inv (invert pattern on load),
//        pat[7:0] (pattern, MSB leftmost), en (output window open), video (registered pixel).
module jace_char_shifter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       inv,
   input  logic [7:0] pat,
   input  logic       en,
   output logic       video
);
   logic [7:0] sr;
   logic [7:0] d;
   always_comb d = inv ? ~pat : pat;
   // sr holds the pixels not yet shown; on load the MSB goes straight to video
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr    <= '0;
         video <= 1'b0;
      end else begin
         sr    <= load ? {d[6:0], 1'b0} : {sr[6:0], 1'b0};
         video <= en & (load ? d[7] : sr[7]);
      end
   end
endmodule

// File: rtl/jace_video_gen.sv
// jace_video_gen: Jupiter Ace PAL 1-bpp video generator with character fetch, syncs and frame interrupt.
// Ports: clk (6.5 MHz pixel clock), rst_n (sync, active low),
//        screen_addr[9:0]/screen_data[7:0] (screen RAM, data 1 clk after address),
//        char_addr[9:0]/char_data[7:0] (pattern RAM, data 1 clk after address),
//        video (1 = white), hsync_n, vsync_n, int_n (all active low, registered).
// Option: define JACE_VIDEO_CSYNC_EN to add csync_n = hsync_n XNOR vsync_n (registered).
module jace_video_gen
   import jace_video_pkg::*;
#(
   parameter int H_TOTAL  = DEF_H_TOTAL,
   parameter int V_TOTAL  = DEF_V_TOTAL,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int HS_START = DEF_HS_START,
   parameter int HS_LEN   = DEF_HS_LEN,
   parameter int VS_START = DEF_VS_START,
   parameter int VS_LEN   = DEF_VS_LEN,
   parameter int INT_LEN  = DEF_INT_LEN
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] screen_addr,
   input  logic [7:0] screen_data,
   output logic [9:0] char_addr,
   input  logic [7:0] char_data,
   output logic       video,
   output logic       hsync_n,
   output logic       vsync_n,
`ifdef JACE_VIDEO_CSYNC_EN
   output logic       csync_n,
`endif
   output logic       int_n
);
   hc_t        hc;
   vc_t        vc;
   logic [7:0] code, pat;
   logic [2:0] ph;
   logic       fetch, load, vis, hs, vs, irq;

   always_comb begin
      ph    = hc[2:0];
      fetch = int'(vc) < V_ACTIVE && int'(hc) < H_ACTIVE;
      load  = fetch && ph == PH_LOAD;
      // video is registered, so the window hc 8..H_ACTIVE+7 is opened one clock early
      vis   = int'(vc) < V_ACTIVE && int'(hc) >= 7 && int'(hc) < H_ACTIVE + 7;
      hs    = in_range(int'(hc), HS_START, HS_LEN);
      vs    = in_range(int'(vc), VS_START, VS_LEN);
      irq   = int'(vc) == VS_START && int'(hc) < INT_LEN;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hc <= '0;
         vc <= '0;
      end else if (int'(hc) == H_TOTAL - 1) begin
         hc <= '0;
         vc <= (int'(vc) == V_TOTAL - 1) ? '0 : vc + 1'b1;
      end else begin
         hc <= hc + 1'b1;
      end
   end

   // each 8-clock cell: address screen, take code, address pattern, take pattern, load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         screen_addr <= '0;
         char_addr   <= '0;
         code        <= '0;
         pat         <= '0;
      end else if (fetch) begin
         if (ph == PH_SADDR) screen_addr <= {vc[7:3], hc[7:3]};
         if (ph == PH_SCODE) code <= screen_data;
         if (ph == PH_CADDR) char_addr <= {code[6:0], vc[2:0]};
         if (ph == PH_PAT) pat <= char_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hsync_n <= 1'b1;
         vsync_n <= 1'b1;
         int_n   <= 1'b1;
`ifdef JACE_VIDEO_CSYNC_EN
         csync_n <= 1'b1;
`endif
      end else begin
         hsync_n <= !hs;
         vsync_n <= !vs;
         int_n   <= !irq;
`ifdef JACE_VIDEO_CSYNC_EN
         csync_n <= !(hs ^ vs);
`endif
      end
   end

   jace_char_shifter u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .inv   (code[7]),
      .pat   (pat),
      .en    (vis),
      .video (video)
   );
endmodule

// File: tb/tb_jace_video_gen.sv
// tb_jace_video_gen: directed self-checking bench for jace_video_gen with a short-frame vertical geometry.
module tb_jace_video_gen;
   localparam int HT = 416, VT = 40, HA = 256, VA = 24;
   localparam int HS = 320, HL = 32, VS = 30, VL = 3, IL = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] screen_addr, char_addr;
   logic [7:0] screen_data = 8'h00, char_data = 8'h00;
   logic       video, hsync_n, vsync_n, int_n;
`ifdef JACE_VIDEO_CSYNC_EN
   logic       csync_n;
`endif
   logic [7:0] scr [768];
   logic [7:0] chr [1024];
   int bhc = 0, bvc = 0, cyc = 0;
   int checks = 0, failures = 0;
   int vfall_cyc = 0;

   always #5 clk = ~clk;

   jace_video_gen #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
      .HS_START(HS), .HS_LEN(HL), .VS_START(VS), .VS_LEN(VL), .INT_LEN(IL)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .screen_addr(screen_addr), .screen_data(screen_data),
      .char_addr(char_addr), .char_data(char_data),
      .video(video), .hsync_n(hsync_n), .vsync_n(vsync_n),
`ifdef JACE_VIDEO_CSYNC_EN
      .csync_n(csync_n),
`endif
      .int_n(int_n)
   );

   // synchronous RAMs and the bench's own raster position
   always @(posedge clk) begin
      screen_data <= scr[screen_addr];
      char_data   <= chr[char_addr];
      cyc <= cyc + 1;
      if (!rst_n) begin
         bhc <= 0;
         bvc <= 0;
      end else if (bhc == HT - 1) begin
         bhc <= 0;
         bvc <= (bvc == VT - 1) ? 0 : bvc + 1;
      end else begin
         bhc <= bhc + 1;
      end
   end

   task automatic goto(input int v, input int h);
      int n = 0;
      while (!(bvc == v && bhc == h) && n < 40000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 40000) begin
         failures++;
         $display("FAIL goto_timeout: at vc=%0d hc=%0d want vc=%0d hc=%0d", bvc, bhc, v, h);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks += 6;
      if (video !== 1'b0)        begin failures++; $display("FAIL %s_video: got %b want 0", tag, video); end
      if (hsync_n !== 1'b1)      begin failures++; $display("FAIL %s_hsync: got %b want 1", tag, hsync_n); end
      if (vsync_n !== 1'b1)      begin failures++; $display("FAIL %s_vsync: got %b want 1", tag, vsync_n); end
      if (int_n !== 1'b1)        begin failures++; $display("FAIL %s_int: got %b want 1", tag, int_n); end
      if (screen_addr !== 10'd0) begin failures++; $display("FAIL %s_saddr: got %0h want 0", tag, screen_addr); end
      if (char_addr !== 10'd0)   begin failures++; $display("FAIL %s_caddr: got %0h want 0", tag, char_addr); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
`ifdef JACE_VIDEO_CSYNC_EN
      checks++;
      if (csync_n !== 1'b1) begin failures++; $display("FAIL reset_csync: got %b want 1", csync_n); end
`endif
      rst_n = 1'b1;
   endtask

   // line 0: cell 0 is code 0x41 (pattern C3), cell 1 is 0xC1 (inverse, 3C)
   task automatic test_fetch();
      logic [7:0] p;
      logic       e;
      goto(0, 2);
      checks++;
      if (screen_addr !== 10'd0) begin failures++; $display("FAIL fetch_saddr0: got %0h want 0", screen_addr); end
      goto(0, 4);
      checks++;
      if (char_addr !== 10'h208) begin failures++; $display("FAIL fetch_caddr0: got %0h want 208", char_addr); end
      goto(0, 10);
      checks++;
      if (screen_addr !== 10'd1) begin failures++; $display("FAIL fetch_saddr1: got %0h want 1", screen_addr); end
      for (int h = 8; h < 24; h++) begin
         goto(0, h);
         p = (h < 16) ? 8'hC3 : 8'h3C;
         e = p[7 - ((h - 8) % 8)];
         checks++;
         if (video !== e) begin failures++; $display("FAIL fetch_pix hc=%0d: got %b want %b", h, video, e); end
      end
      goto(0, 263);
      checks++;
      if (video !== 1'b1) begin failures++; $display("FAIL last_pixel: got %b want 1", video); end
      goto(0, 264);
      checks++;
      if (video !== 1'b0) begin failures++; $display("FAIL after_last: got %b want 0", video); end
      goto(0, 300);
      checks += 2;
      if (screen_addr !== 10'd31) begin failures++; $display("FAIL no_fetch_saddr: got %0h want 1f", screen_addr); end
      if (char_addr !== 10'h208)  begin failures++; $display("FAIL no_fetch_caddr: got %0h want 208", char_addr); end
   endtask

   // whole line: cell 1 shows p1, all other cells p0, black outside hc 8..263
   task automatic test_line(input int v, input logic [7:0] p0, input logic [7:0] p1);
      logic [7:0] p;
      logic       e;
      for (int h = 0; h < HT; h++) begin
         goto(v, h);
         p = ((h - 8) / 8 == 1) ? p1 : p0;
         e = (h >= 8 && h < 264) ? p[7 - ((h - 8) % 8)] : 1'b0;
         checks++;
         if (video !== e) begin
            failures++;
            $display("FAIL line_pix vc=%0d hc=%0d: got %b want %b", v, h, video, e);
         end
      end
   endtask

   task automatic test_alternate();
      test_line(1, 8'hAB, 8'h54);
      test_line(2, 8'hC3, 8'h3C);
      test_line(3, 8'hAB, 8'h54);
   endtask

   task automatic test_rows();
      test_line(9, 8'hAB, 8'hAB);
      test_line(16, 8'hFF, 8'hFF);
   endtask

   task automatic test_hsync();
      int n = 0, m = 0;
      goto(20, 320);
      checks++;
      if (hsync_n !== 1'b1) begin failures++; $display("FAIL hsync_pre: got %b want 1", hsync_n); end
      goto(20, 321);
      while (hsync_n === 1'b0 && n < 500) begin n++; @(negedge clk); end
      checks++;
      if (n != HL) begin failures++; $display("FAIL hsync_width: got %0d want %0d", n, HL); end
      while (hsync_n !== 1'b0 && m < 1000) begin m++; @(negedge clk); end
      checks++;
      if (n + m != HT) begin failures++; $display("FAIL hsync_period: got %0d want %0d", n + m, HT); end
   endtask

   task automatic test_blank();
      test_line(23, 8'hFF, 8'hFF);
      test_line(24, 8'h00, 8'h00);
   endtask

   task automatic test_vsync_int();
      int nv = 0, ni = 0;
      goto(VS, 0);
      checks += 2;
      if (vsync_n !== 1'b1) begin failures++; $display("FAIL vsync_pre: got %b want 1", vsync_n); end
      if (int_n !== 1'b1)   begin failures++; $display("FAIL int_pre: got %b want 1", int_n); end
      goto(VS, 1);
      vfall_cyc = cyc;
      checks++;
      if (int_n !== 1'b0) begin failures++; $display("FAIL int_start: got %b want 0", int_n); end
      while (vsync_n === 1'b0 && nv < 5000) begin
         nv++;
         if (int_n === 1'b0) ni++;
         @(negedge clk);
      end
      checks += 2;
      if (nv != VL * HT) begin failures++; $display("FAIL vsync_width: got %0d want %0d", nv, VL * HT); end
      if (ni != IL)      begin failures++; $display("FAIL int_width: got %0d want %0d", ni, IL); end
   endtask

   task automatic test_frame_period();
      int n = 0, nint = 0;
      logic prev = int_n;
      while (vsync_n !== 1'b0 && n < 20000) begin
         @(negedge clk);
         n++;
         if (prev === 1'b1 && int_n === 1'b0) nint++;
         prev = int_n;
      end
      checks += 2;
      if (cyc - vfall_cyc != VT * HT) begin
         failures++;
         $display("FAIL frame_period: got %0d want %0d", cyc - vfall_cyc, VT * HT);
      end
      if (nint != 1) begin failures++; $display("FAIL int_per_frame: got %0d want 1", nint); end
   endtask

   task automatic test_mid_reset();
      int rel, n = 0;
      logic [7:0] p = 8'hC3;
      goto(10, 200);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("midreset");
      rst_n = 1'b1;
      rel = cyc;
      goto(0, 4);
      checks++;
      if (char_addr !== 10'h208) begin failures++; $display("FAIL midreset_caddr: got %0h want 208", char_addr); end
      for (int h = 8; h < 16; h++) begin
         goto(0, h);
         checks++;
         if (video !== p[15 - h]) begin failures++; $display("FAIL midreset_pix hc=%0d: got %b want %b", h, video, p[15 - h]); end
      end
      while (vsync_n !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
      // one clock of registered-output latency after vc=VS_START, hc=0
      checks++;
      if (cyc - rel != VS * HT + 1) begin
         failures++;
         $display("FAIL midreset_vsync: got %0d want %0d", cyc - rel, VS * HT + 1);
      end
   endtask

   initial begin
      for (int i = 0; i < 768; i++) scr[i] = (i < 64) ? 8'h41 : 8'h00;
      scr[1] = 8'hC1;
      for (int i = 0; i < 1024; i++) chr[i] = 8'h00;
      for (int r = 0; r < 8; r++) begin
         chr[r] = 8'hFF;
         chr[8'h41 * 8 + r] = (r % 2 == 1) ? 8'hAB : 8'hC3;
      end
      @(negedge clk);
      test_reset();
      test_fetch();
      test_alternate();
      test_rows();
      test_hsync();
      test_blank();
      test_vsync_int();
      test_frame_period();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
